i2c_target: RTL and testbench

I2C target (slave) endpoint that answers the on-chip I2C controller, or any standard 7-bit-address controller, on the shared SCL/SDA pins. It decodes START/STOP, matches its address, and shifts up to four data bytes into a 32-bit receive word on writes. On reads it serves up to four bytes from a 32-bit transmit word. It sits between the pad-level SDA/SCL signals and a simple word-wide register interface for the SoC.

---
 rtl/i2c_target.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// 7-bit-address I2C target: receives up to four bytes into rx_data and serves up to four bytes from tx_data.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample glitch filter after the synchronizers.
module i2c_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_oe,
    input  logic [6:0]  own_addr,
    input  logic [31:0] tx_data,
    input  logic [3:0]  tx_mask,
    output logic [31:0] rx_data,
    output logic [3:0]  rx_mask,
    output logic        rx_valid,
    output logic        tx_load,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_c, sda_c, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [7:0]  shreg;
    logic        ack_half, rw, in_write;
    logic [31:0] tx_word;
    logic [3:0]  tx_rem;
    logic [7:0]  rx_byte;
    logic        addr_hit;
    logic [11:0] first_tx, more_tx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_cnt, sda_cnt;
    // Output follows the input only once three consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_c   <= 1'b1;
            sda_c   <= 1'b1;
            scl_cnt <= 2'd0;
            sda_cnt <= 2'd0;
        end else begin
            if (scl_s == scl_c) scl_cnt <= 2'd0;
            else if (scl_cnt == 2'd2) begin scl_c <= scl_s; scl_cnt <= 2'd0; end
            else scl_cnt <= scl_cnt + 2'd1;
            if (sda_s == sda_c) sda_cnt <= 2'd0;
            else if (sda_cnt == 2'd2) begin sda_c <= sda_s; sda_cnt <= 2'd0; end
            else sda_cnt <= sda_cnt + 2'd1;
        end
    end
`else
    assign scl_c = scl_s;
    assign sda_c = sda_s;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_c;
            sda_q <= sda_c;
        end
    end

    assign scl_rise  = scl_c & ~scl_q;
    assign scl_fall  = ~scl_c & scl_q;
    assign start_det = scl_c & scl_q & sda_q & ~sda_c;
    assign stop_det  = scl_c & scl_q & ~sda_q & sda_c;

    // Returns {remaining mask, byte}: highest set index first, 8'hFF once the mask is empty.
    function automatic logic [11:0] next_byte(input logic [31:0] w, input logic [3:0] m);
        logic [11:0] r;
        logic [3:0]  one;
        r = {4'b0000, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            one = 4'b0001 << i;
            if (m[i]) r = {m & ~one, w[8*i +: 8]};
        end
        return r;
    endfunction

    assign rx_byte  = {shreg[6:0], sda_c};
    assign addr_hit = (shreg[6:0] == own_addr);
    assign first_tx = next_byte(tx_data, tx_mask);
    assign more_tx  = next_byte(tx_word, tx_rem);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ADDR:     if (scl_rise && bit_cnt == 4'd0) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK: if (scl_fall && ack_half) state_nxt = rw ? TX_BYTE : RX_BYTE;
            RX_BYTE:  if (scl_rise && bit_cnt == 4'd0) state_nxt = (byte_cnt < 3'd4) ? RX_ACK : WAIT_STOP;
            RX_ACK:   if (scl_fall && ack_half) state_nxt = RX_BYTE;
            TX_BYTE:  if (scl_fall && bit_cnt == 4'd0) state_nxt = TX_ACK;
            TX_ACK:   if (scl_rise) state_nxt = sda_c ? WAIT_STOP : TX_BYTE;
            default:  state_nxt = state;
        endcase
        if (start_det) state_nxt = ADDR;
        if (stop_det)  state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sda_o <= 1'b1;  sda_oe <= 1'b0;
            rx_data <= '0;  rx_mask <= '0;
            rx_valid <= 1'b0; tx_load <= 1'b0; busy <= 1'b0;
            bit_cnt <= 4'd7; byte_cnt <= 3'd0; shreg <= '0;
            ack_half <= 1'b0; rw <= 1'b0; in_write <= 1'b0;
            tx_word <= '0; tx_rem <= '0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            if (start_det || stop_det) begin
                rx_valid <= in_write && (rx_mask != 4'd0);
                in_write <= 1'b0; busy <= 1'b0;
                sda_oe <= 1'b0; sda_o <= 1'b1;
                bit_cnt <= 4'd7; byte_cnt <= 3'd0; shreg <= '0; ack_half <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd0) begin
                            rw <= sda_c;
                            if (addr_hit) begin
                                busy     <= 1'b1;
                                in_write <= ~sda_c;
                                if (!sda_c) begin rx_data <= '0; rx_mask <= '0; end
                            end
                        end else bit_cnt <= bit_cnt - 4'd1;
                    end
                    ADDR_ACK, RX_ACK: if (scl_fall) begin
                        if (!ack_half) begin
                            ack_half <= 1'b1; sda_oe <= 1'b1; sda_o <= 1'b0;
                        end else begin
                            ack_half <= 1'b0;
                            bit_cnt  <= 4'd7;
                            if (state == ADDR_ACK && rw) begin
                                tx_word <= tx_data;
                                tx_rem  <= first_tx[11:8];
                                shreg   <= first_tx[7:0];
                                sda_oe  <= 1'b1;
                                sda_o   <= first_tx[7];
                                tx_load <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0; sda_o <= 1'b1;
                            end
                        end
                    end
                    RX_BYTE: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt != 4'd0) bit_cnt <= bit_cnt - 4'd1;
                        else if (byte_cnt < 3'd4) begin
                            rx_data  <= {rx_data[23:0], rx_byte};
                            rx_mask  <= {rx_mask[2:0], 1'b1};
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    // bit_cnt==8 marks a freshly loaded byte whose MSB goes out on the next fall.
                    TX_BYTE: if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe <= 1'b0; sda_o <= 1'b1;
                        end else if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1; sda_o <= shreg[7]; bit_cnt <= 4'd7;
                        end else begin
                            sda_o   <= shreg[6];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end
                    TX_ACK: if (scl_rise && !sda_c) begin
                        tx_rem  <= more_tx[11:8];
                        shreg   <= more_tx[7:0];
                        bit_cnt <= 4'd8;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C controller plus a transaction-level reference model.
module tb_i2c_target;
    localparam int Q = 8;

    logic        clk = 1'b0, reset = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
    logic        sda_o, sda_oe, rx_valid, tx_load, busy, sda_line;
    logic [6:0]  own_addr = 7'h42;
    logic [31:0] tx_data = '0, rx_data;
    logic [3:0]  tx_mask = '0, rx_mask;
    int tests = 0, fails = 0;
    int rxv_cnt = 0, txl_cnt = 0, oe_cnt = 0, busy_cnt = 0;

    assign sda_line = m_sda & ~(sda_oe & ~sda_o);
    always #5 clk = ~clk;

    i2c_target #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl_i(m_scl), .sda_i(sda_line),
        .sda_o(sda_o), .sda_oe(sda_oe), .own_addr(own_addr),
        .tx_data(tx_data), .tx_mask(tx_mask), .rx_data(rx_data), .rx_mask(rx_mask),
        .rx_valid(rx_valid), .tx_load(tx_load), .busy(busy)
    );

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (tx_load)  txl_cnt++;
        if (sda_oe)   oe_cnt++;
        if (busy)     busy_cnt++;
    end

    // Controller-side bus primitives.
    task automatic qw(); repeat (Q) @(negedge clk); endtask
    task automatic bit_out(input logic b);
        m_sda = b; qw(); m_scl = 1'b1; qw(); qw(); m_scl = 1'b0; qw();
    endtask
    task automatic bit_in(output logic b);
        m_sda = 1'b1; qw(); m_scl = 1'b1; qw(); b = sda_line; qw(); m_scl = 1'b0; qw();
    endtask
    task automatic start_c();
        m_sda = 1'b1; qw(); m_scl = 1'b1; qw(); m_sda = 1'b0; qw(); m_scl = 1'b0; qw();
    endtask
    task automatic stop_c();
        m_sda = 1'b0; qw(); m_scl = 1'b1; qw(); m_sda = 1'b1; qw(); qw();
    endtask
    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(ack);
    endtask
    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_in(b[i]);
        bit_out(nack);
    endtask
    task automatic write_xfer(input logic [6:0] a, input logic [39:0] bytes, input int n, output logic [5:0] acks);
        logic ack;
        acks = '1;
        start_c();
        write_byte({a, 1'b0}, ack); acks[0] = ack;
        for (int i = 0; i < n; i++) begin write_byte(bytes[8*i +: 8], ack); acks[i+1] = ack; end
        stop_c();
    endtask
    task automatic read_xfer(input logic [6:0] a, input int n, input logic nack_last,
                             output logic addr_ack, output logic [39:0] got);
        logic [7:0] b;
        got = '0;
        start_c();
        write_byte({a, 1'b1}, addr_ack);
        for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1) ? nack_last : 1'b0, b);
            got[8*i +: 8] = b;
        end
        stop_c();
    endtask

    // Reference model: served byte k of a read, and the write-side results.
    function automatic logic [7:0] exp_tx(input logic [31:0] d, input logic [3:0] m, input int k);
        int seen = 0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) begin
                if (seen == k) return d[8*i +: 8];
                seen++;
            end
        return 8'hFF;
    endfunction
    function automatic logic [5:0] exp_acks(input logic match, input int n);
        logic [5:0] r = '1;
        if (match) begin
            r[0] = 1'b0;
            for (int i = 0; i < n && i < 4; i++) r[i+1] = 1'b0;
        end
        return r;
    endfunction
    function automatic logic [31:0] exp_rxd(input logic [39:0] bytes, input int n);
        logic [31:0] acc = '0;
        for (int i = 0; i < n && i < 4; i++) acc = (acc << 8) | 32'(bytes[8*i +: 8]);
        return acc;
    endfunction
    function automatic logic [3:0] exp_rxm(input int n);
        return 4'((1 << ((n < 4) ? n : 4)) - 1);
    endfunction

    task automatic test_reset();
        reset = 1'b0; repeat (4) @(negedge clk);
        tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
        tests++; if (sda_o !== 1'b1) begin fails++; $display("FAIL reset_sda_o got %b exp 1", sda_o); end
        tests++; if (rx_data !== 32'h0 || rx_mask !== 4'h0) begin fails++; $display("FAIL reset_rx got %h/%b exp 0/0", rx_data, rx_mask); end
        tests++; if ({rx_valid, tx_load, busy} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b exp 000", {rx_valid, tx_load, busy}); end
        reset = 1'b1; repeat (4) @(negedge clk);
    endtask

    task automatic test_write_basic();
        logic [5:0] acks;
        int rxv0 = rxv_cnt, b0 = busy_cnt;
        own_addr = 7'h42;
        write_xfer(7'h42, 40'h3CA5, 2, acks);
        tests++; if (acks !== exp_acks(1'b1, 2)) begin fails++; $display("FAIL wr_basic_acks got %b exp %b", acks, exp_acks(1'b1, 2)); end
        tests++; if (rx_data !== 32'h0000A53C) begin fails++; $display("FAIL wr_basic_data got %h exp 0000a53c", rx_data); end
        tests++; if (rx_mask !== 4'b0011) begin fails++; $display("FAIL wr_basic_mask got %b exp 0011", rx_mask); end
        tests++; if (rxv_cnt - rxv0 !== 1) begin fails++; $display("FAIL wr_basic_rxvalid got %0d exp 1", rxv_cnt - rxv0); end
        tests++; if (busy_cnt == b0 || busy !== 1'b0) begin fails++; $display("FAIL wr_basic_busy got cycles=%0d now=%b exp >0/0", busy_cnt - b0, busy); end
    endtask

    task automatic test_read_basic();
        logic ack; logic [39:0] got;
        int t0 = txl_cnt;
        own_addr = 7'h42; tx_data = 32'h11223344; tx_mask = 4'b0011;
        read_xfer(7'h42, 2, 1'b0, ack, got);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rd_basic_addr_ack got %b exp 0", ack); end
        tests++; if (txl_cnt - t0 !== 1) begin fails++; $display("FAIL rd_basic_txload got %0d exp 1", txl_cnt - t0); end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (got[8*k +: 8] !== exp_tx(32'h11223344, 4'b0011, k)) begin
                fails++; $display("FAIL rd_basic_byte%0d got %h exp %h", k, got[8*k +: 8], exp_tx(32'h11223344, 4'b0011, k));
            end
        end
    endtask

    task automatic test_mismatch();
        logic [5:0] acks;
        logic [31:0] d0 = rx_data;
        int rxv0 = rxv_cnt, oe0 = oe_cnt, b0 = busy_cnt;
        own_addr = 7'h42;
        write_xfer(7'h43, 40'h5566, 2, acks);
        tests++; if (acks !== 6'b111111) begin fails++; $display("FAIL mismatch_acks got %b exp 111111", acks); end
        tests++; if (oe_cnt != oe0 || busy_cnt != b0) begin fails++; $display("FAIL mismatch_drive got oe=%0d busy=%0d exp 0/0", oe_cnt - oe0, busy_cnt - b0); end
        tests++; if (rxv_cnt != rxv0 || rx_data !== d0) begin fails++; $display("FAIL mismatch_rx got v=%0d d=%h exp 0/%h", rxv_cnt - rxv0, rx_data, d0); end
    endtask

    task automatic test_overflow();
        logic [5:0] acks;
        own_addr = 7'h42;
        write_xfer(7'h42, 40'h0504030201, 5, acks);
        tests++; if (acks !== 6'b100000) begin fails++; $display("FAIL overflow_acks got %b exp 100000", acks); end
        tests++; if (rx_data !== 32'h01020304 || rx_mask !== 4'b1111) begin fails++; $display("FAIL overflow_rx got %h/%b exp 01020304/1111", rx_data, rx_mask); end
    endtask

    task automatic test_restart();
        logic ack; logic [7:0] b, wb, rb;
        logic [31:0] td;
        int rxv0 = rxv_cnt;
        wb = 8'($urandom); td = $urandom;
        own_addr = 7'h42; tx_data = td; tx_mask = 4'b0001;
        start_c();
        write_byte({7'h42, 1'b0}, ack);
        write_byte(wb, ack);
        start_c();
        tests++; if (rxv_cnt - rxv0 !== 1) begin fails++; $display("FAIL restart_rxvalid got %0d exp 1", rxv_cnt - rxv0); end
        tests++; if (rx_data !== {24'h0, wb} || rx_mask !== 4'b0001) begin fails++; $display("FAIL restart_rx got %h/%b exp %h/0001", rx_data, rx_mask, {24'h0, wb}); end
        write_byte({7'h42, 1'b1}, ack);
        read_byte(1'b1, rb);
        stop_c();
        b = td[7:0];
        tests++; if (ack !== 1'b0 || rb !== b) begin fails++; $display("FAIL restart_read got ack=%b %h exp 0/%h", ack, rb, b); end
        tests++; if (rxv_cnt - rxv0 !== 1) begin fails++; $display("FAIL restart_read_rxvalid got %0d exp 1", rxv_cnt - rxv0); end
    endtask

    task automatic test_reset_mid();
        logic ack; logic [5:0] acks;
        int oe0;
        own_addr = 7'h42;
        start_c();
        write_byte({7'h42, 1'b0}, ack);
        for (int i = 7; i >= 0; i--) bit_out(1'(8'h9A >> i));
        m_sda = 1'b1; qw();
        tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL midreset_pre_oe got %b exp 1", sda_oe); end
        reset = 1'b0; @(negedge clk);
        tests++; if (sda_oe !== 1'b0 || sda_o !== 1'b1) begin fails++; $display("FAIL midreset_release got oe=%b o=%b exp 0/1", sda_oe, sda_o); end
        tests++; if (rx_data !== 32'h0 || rx_mask !== 4'h0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_state got %h/%b/%b exp 0/0/0", rx_data, rx_mask, busy); end
        repeat (3) @(negedge clk);
        reset = 1'b1; repeat (2) @(negedge clk);
        oe0 = oe_cnt;
        m_scl = 1'b1; qw(); m_scl = 1'b0; qw(); bit_out(1'b0); bit_out(1'b1);
        tests++; if (oe_cnt != oe0) begin fails++; $display("FAIL midreset_ignore got oe=%0d exp 0", oe_cnt - oe0); end
        stop_c();
        write_xfer(7'h42, 40'h77, 1, acks);
        tests++; if (acks !== exp_acks(1'b1, 1) || rx_data !== 32'h77 || rx_mask !== 4'b0001) begin
            fails++; $display("FAIL midreset_after got %b %h/%b exp %b 00000077/0001", acks, rx_data, rx_mask, exp_acks(1'b1, 1));
        end
    endtask

    task automatic test_random_write();
        logic [5:0] acks; logic [39:0] bytes; logic [6:0] a;
        logic [31:0] d0, ed; logic [3:0] m0, em;
        logic match; int n, rxv0;
        for (int it = 0; it < 5; it++) begin
            own_addr = 7'($urandom);
            match = ($urandom_range(0, 3) != 0);
            a = match ? own_addr : own_addr ^ 7'($urandom_range(1, 127));
            n = $urandom_range(1, 5);
            bytes = {8'($urandom), $urandom};
            d0 = rx_data; m0 = rx_mask; rxv0 = rxv_cnt;
            write_xfer(a, bytes, n, acks);
            ed = match ? exp_rxd(bytes, n) : d0;
            em = match ? exp_rxm(n) : m0;
            tests++; if (acks !== exp_acks(match, n)) begin fails++; $display("FAIL rnd_wr%0d_acks got %b exp %b", it, acks, exp_acks(match, n)); end
            tests++; if (rx_data !== ed || rx_mask !== em) begin fails++; $display("FAIL rnd_wr%0d_rx got %h/%b exp %h/%b", it, rx_data, rx_mask, ed, em); end
            tests++; if (rxv_cnt - rxv0 !== (match ? 1 : 0)) begin fails++; $display("FAIL rnd_wr%0d_rxvalid got %0d exp %0d", it, rxv_cnt - rxv0, match ? 1 : 0); end
        end
    endtask

    task automatic test_random_read();
        logic ack; logic [39:0] got; int n, t0;
        for (int it = 0; it < 4; it++) begin
            own_addr = 7'($urandom);
            tx_data = $urandom; tx_mask = 4'($urandom);
            n = $urandom_range(1, 5);
            t0 = txl_cnt;
            read_xfer(own_addr, n, 1'b1, ack, got);
            tests++; if (ack !== 1'b0 || txl_cnt - t0 !== 1) begin fails++; $display("FAIL rnd_rd%0d_addr got ack=%b load=%0d exp 0/1", it, ack, txl_cnt - t0); end
            for (int k = 0; k < n; k++) begin
                tests++;
                if (got[8*k +: 8] !== exp_tx(tx_data, tx_mask, k)) begin
                    fails++; $display("FAIL rnd_rd%0d_byte%0d got %h exp %h (mask %b)", it, k, got[8*k +: 8], exp_tx(tx_data, tx_mask, k), tx_mask);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_mismatch();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_random_write();
        test_random_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
